// File: rtl/epochtv1_vram_arb.sv
// VRAM access arbiter for the EPOCH TV-1: shares banks A/B between video fetch (read-only)
// and the CPU port, with video priority and a bounded CPU starvation counter.
`timescale 1ns/1ps
module epochtv1_vram_arb #(
  parameter int unsigned CPU_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        vid_req,
  input  logic [11:0] vid_a,
  output logic        vid_ack,
  output logic [7:0]  vid_d,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_a,
  input  logic [7:0]  cpu_di,
  output logic        cpu_ack,
  output logic [7:0]  cpu_do,
  output logic [10:0] va,
  input  logic [7:0]  vd_i,
  output logic [7:0]  vd_o,
  output logic        n_vwe,
  output logic [1:0]  n_vcs
);

  localparam int unsigned STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(CPU_STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACC, DATA} state_t;

  state_t              state;
  logic                owner_cpu;
  logic                we_q;
  logic [STARVE_W-1:0] starve;
  logic                cpu_win_c;

  // CPU overrides video once the starvation limit is reached
  always_comb begin
    cpu_win_c = 1'b0;
    cpu_win_c = cpu_req && (!vid_req || (starve == STARVE_LIM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner_cpu <= 1'b0;
      we_q      <= 1'b0;
      starve    <= '0;
      va        <= '0;
      vd_o      <= '0;
      n_vwe     <= 1'b1;
      n_vcs     <= 2'b11;
      vid_ack   <= 1'b0;
      cpu_ack   <= 1'b0;
      vid_d     <= '0;
      cpu_do    <= '0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          vid_ack <= 1'b0;
          cpu_ack <= 1'b0;
          n_vcs   <= 2'b11;
          n_vwe   <= 1'b1;
          if (!cpu_req) starve <= '0;
          if (cpu_win_c) begin
            // Bus outputs are loaded at grant so they are valid throughout ACC
            owner_cpu <= 1'b1;
            we_q      <= cpu_we;
            starve    <= '0;
            va        <= cpu_a[10:0];
            vd_o      <= cpu_di;
            n_vwe     <= ~cpu_we;
            n_vcs     <= cpu_a[11] ? 2'b01 : 2'b10;
            state     <= ACC;
          end else if (vid_req) begin
            owner_cpu <= 1'b0;
            we_q      <= 1'b0;
            if (cpu_req && (starve != STARVE_LIM)) starve <= starve + STARVE_W'(1);
            va        <= vid_a[10:0];
            n_vwe     <= 1'b1;
            n_vcs     <= vid_a[11] ? 2'b01 : 2'b10;
            state     <= ACC;
          end
        end
        ACC: begin
          // A write completes in ACC; reads keep the select for the data phase
          n_vwe <= 1'b1;
          if (we_q) n_vcs <= 2'b11;
          state <= DATA;
        end
        DATA: begin
          n_vcs <= 2'b11;
          n_vwe <= 1'b1;
          if (owner_cpu) begin
            cpu_ack <= 1'b1;
            if (!we_q) cpu_do <= vd_i;
          end else begin
            vid_ack <= 1'b1;
            vid_d   <= vd_i;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epochtv1_vram_arb.sv
// Directed self-checking bench for epochtv1_vram_arb with a two-bank synchronous VRAM model.
`timescale 1ns/1ps
module tb_epochtv1_vram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        vid_req;
  logic [11:0] vid_a;
  logic        vid_ack;
  logic [7:0]  vid_d;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_a;
  logic [7:0]  cpu_di;
  logic        cpu_ack;
  logic [7:0]  cpu_do;
  logic [10:0] va;
  logic [7:0]  vd_i = 8'h00;
  logic [7:0]  vd_o;
  logic        n_vwe;
  logic [1:0]  n_vcs;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem_a [2048];
  logic [7:0] mem_b [2048];

  epochtv1_vram_arb #(.CPU_STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .vid_req(vid_req), .vid_a(vid_a), .vid_ack(vid_ack), .vid_d(vid_d),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_di(cpu_di),
    .cpu_ack(cpu_ack), .cpu_do(cpu_do),
    .va(va), .vd_i(vd_i), .vd_o(vd_o), .n_vwe(n_vwe), .n_vcs(n_vcs)
  );

  always #5 clk = ~clk;

  // Synchronous VRAM: read data appears one clock after select
  always @(posedge clk) begin
    if (!n_vcs[0]) begin
      if (!n_vwe) mem_a[va] <= vd_o;
      vd_i <= mem_a[va];
    end else if (!n_vcs[1]) begin
      if (!n_vwe) mem_b[va] <= vd_o;
      vd_i <= mem_b[va];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one CPU access and waits (bounded) for its ACK; no checking here
  task automatic do_cpu(input logic we, input logic [11:0] a, input logic [7:0] d,
                        output logic [7:0] rdata, output logic acked);
    cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_di = d;
    step();
    cpu_req = 1'b0;
    acked = 1'b0;
    rdata = 8'h00;
    for (int i = 0; i < 10 && !acked; i++) begin
      step();
      if (cpu_ack) begin acked = 1'b1; rdata = cpu_do; end
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1;
    vid_req = 1'b0; vid_a = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_di = '0;
    repeat (3) step();
    total++; if (n_vcs !== 2'b11) $display("FAIL reset_nvcs got %b want 11", n_vcs); else passed++;
    total++; if (n_vwe !== 1'b1) $display("FAIL reset_nvwe got %b want 1", n_vwe); else passed++;
    total++; if ({vid_ack, cpu_ack} !== 2'b00) $display("FAIL reset_acks got %b want 00", {vid_ack, cpu_ack}); else passed++;
    total++; if (va !== 11'h000) $display("FAIL reset_va got %h want 000", va); else passed++;
    total++; if (vd_o !== 8'h00) $display("FAIL reset_vdo got %h want 00", vd_o); else passed++;
    total++; if ({vid_d, cpu_do} !== 16'h0000) $display("FAIL reset_data got %h want 0000", {vid_d, cpu_do}); else passed++;
    rst_n = 1'b1;
    repeat (3) step();
    total++; if ({n_vcs, n_vwe, vid_ack, cpu_ack} !== 5'b11100) $display("FAIL idle_bus got %b want 11100", {n_vcs, n_vwe, vid_ack, cpu_ack}); else passed++;
  endtask

  task automatic test_cpu_bank_a();
    logic [7:0] rd; logic ok;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 12'h123; cpu_di = 8'h5A;
    step();
    cpu_req = 1'b0; cpu_a = 12'hFFF; cpu_di = 8'h00;
    total++; if ({va, n_vcs, n_vwe} !== {11'h123, 2'b10, 1'b0}) $display("FAIL wr_a_acc got va=%h nvcs=%b nvwe=%b want 123/10/0", va, n_vcs, n_vwe); else passed++;
    total++; if (vd_o !== 8'h5A) $display("FAIL wr_a_vdo got %h want 5a", vd_o); else passed++;
    step();
    total++; if ({n_vcs, n_vwe, cpu_ack} !== 4'b1110) $display("FAIL wr_a_data got %b want 1110", {n_vcs, n_vwe, cpu_ack}); else passed++;
    step();
    total++; if (cpu_ack !== 1'b1) $display("FAIL wr_a_ack got %b want 1", cpu_ack); else passed++;
    step();
    total++; if (cpu_ack !== 1'b0) $display("FAIL wr_a_ack_clear got %b want 0", cpu_ack); else passed++;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h123;
    step();
    cpu_req = 1'b0;
    total++; if ({n_vcs, n_vwe} !== 3'b101) $display("FAIL rd_a_acc got %b want 101", {n_vcs, n_vwe}); else passed++;
    step();
    total++; if ({n_vcs, n_vwe} !== 3'b101) $display("FAIL rd_a_data got %b want 101", {n_vcs, n_vwe}); else passed++;
    step();
    total++; if ({cpu_ack, cpu_do} !== {1'b1, 8'h5A}) $display("FAIL rd_a_result got ack=%b do=%h want 1/5a", cpu_ack, cpu_do); else passed++;
    step();
    do_cpu(1'b0, 12'h123, 8'h00, rd, ok);
    total++; if ({ok, rd} !== {1'b1, 8'h5A}) $display("FAIL rd_a_again got ok=%b d=%h want 1/5a", ok, rd); else passed++;
  endtask

  task automatic test_bank_b();
    logic [7:0] rd; logic ok;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 12'h923; cpu_di = 8'hA5;
    step();
    cpu_req = 1'b0;
    total++; if ({va, n_vcs, n_vwe} !== {11'h123, 2'b01, 1'b0}) $display("FAIL wr_b_acc got va=%h nvcs=%b nvwe=%b want 123/01/0", va, n_vcs, n_vwe); else passed++;
    repeat (3) step();
    do_cpu(1'b0, 12'h123, 8'h00, rd, ok);
    total++; if ({ok, rd} !== {1'b1, 8'h5A}) $display("FAIL bank_a_intact got ok=%b d=%h want 1/5a", ok, rd); else passed++;
    do_cpu(1'b0, 12'h923, 8'h00, rd, ok);
    total++; if ({ok, rd} !== {1'b1, 8'hA5}) $display("FAIL bank_b_read got ok=%b d=%h want 1/a5", ok, rd); else passed++;
  endtask

  task automatic test_contention();
    logic [7:0] rd; logic ok;
    string got;
    int last_cpu;
    do_cpu(1'b1, 12'h010, 8'h3C, rd, ok);
    vid_req = 1'b1; vid_a = 12'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 12'h923;
    got = "";
    last_cpu = 0;
    for (int cyc = 1; cyc <= 60 && got.len() < 10; cyc++) begin
      step();
      if (vid_ack) begin
        got = {got, "V"};
        total++; if (vid_d !== 8'h3C) $display("FAIL cont_vid_d got %h want 3c", vid_d); else passed++;
      end
      if (cpu_ack) begin
        got = {got, "C"};
        total++; if (cpu_do !== 8'hA5) $display("FAIL cont_cpu_do got %h want a5", cpu_do); else passed++;
        total++; if (cyc - last_cpu > 15) $display("FAIL cont_cpu_gap got %0d want <=15", cyc - last_cpu); else passed++;
        last_cpu = cyc;
      end
    end
    total++; if (got != "VVVVCVVVVC") $display("FAIL cont_sequence got %s want VVVVCVVVVC", got); else passed++;
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_ce_gating();
    logic [7:0] rd; logic ok;
    do_cpu(1'b1, 12'h011, 8'h77, rd, ok);
    vid_req = 1'b1; vid_a = 12'h011; ce = 1'b1;
    step();
    vid_req = 1'b0; ce = 1'b0;
    total++; if ({n_vcs, va} !== {2'b10, 11'h011}) $display("FAIL ce_acc got nvcs=%b va=%h want 10/011", n_vcs, va); else passed++;
    step();
    ce = 1'b1;
    total++; if ({n_vcs, vid_ack} !== 3'b100) $display("FAIL ce_acc_hold got %b want 100", {n_vcs, vid_ack}); else passed++;
    step();
    ce = 1'b0;
    total++; if ({n_vcs, n_vwe, vid_ack} !== 4'b1010) $display("FAIL ce_data got %b want 1010", {n_vcs, n_vwe, vid_ack}); else passed++;
    step();
    ce = 1'b1;
    total++; if (vid_ack !== 1'b0) $display("FAIL ce_data_hold got %b want 0", vid_ack); else passed++;
    step();
    ce = 1'b0;
    total++; if ({vid_ack, vid_d, n_vcs} !== {1'b1, 8'h77, 2'b11}) $display("FAIL ce_ack got ack=%b d=%h nvcs=%b want 1/77/11", vid_ack, vid_d, n_vcs); else passed++;
    step();
    ce = 1'b1;
    total++; if (vid_ack !== 1'b1) $display("FAIL ce_ack_hold got %b want 1", vid_ack); else passed++;
    step();
    total++; if (vid_ack !== 1'b0) $display("FAIL ce_ack_clear got %b want 0", vid_ack); else passed++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 12'h124; cpu_di = 8'h99;
    step();
    total++; if ({n_vcs, n_vwe} !== 3'b100) $display("FAIL mid_acc got %b want 100", {n_vcs, n_vwe}); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({n_vcs, n_vwe} !== 3'b111) $display("FAIL mid_async got %b want 111", {n_vcs, n_vwe}); else passed++;
    seen = 1'b0;
    repeat (2) begin step(); if (cpu_ack) seen = 1'b1; end
    total++; if ({seen, vd_o} !== 9'h000) $display("FAIL mid_no_ack got ack=%b vdo=%h want 0/00", seen, vd_o); else passed++;
    rst_n = 1'b1;
    step();
    cpu_req = 1'b0;
    total++; if ({va, n_vcs, n_vwe} !== {11'h124, 2'b10, 1'b0}) $display("FAIL mid_regrant got va=%h nvcs=%b nvwe=%b want 124/10/0", va, n_vcs, n_vwe); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin step(); if (cpu_ack) seen = 1'b1; end
    total++; if (seen !== 1'b1) $display("FAIL mid_regrant_ack got %b want 1", seen); else passed++;
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_bank_a();
    test_bank_b();
    test_contention();
    test_ce_gating();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/epochtv1_vram_arb.md
# epochtv1_vram_arb

VRAM access arbiter for the EPOCH TV-1 video controller. It shares the two external 2 KB VRAM banks (A and B) between two requesters: the display fetch engine, which reads only, and the host CPU port, which reads and writes. It drives the VRAM bus (VA, VD_O, nVWE, nVCS) and returns read data to whichever requester was granted. Video has priority, and a bounded-starvation counter guarantees the CPU forward progress.

## Interface
- CPU_STARVE_MAX, default 4: maximum number of consecutive video grants while CPU_REQ is pending. Legal range 1..15.

- CLK  in  1  system clock
- nRST  in  1  asynchronous, active-low reset
- CE  in  1  clock enable; all state advances only on CLK edges with CE=1
- VID_REQ  in  1  video fetch request, level
- VID_A  in  12  video address; bit 11 is the bank select, bits 10:0 the bank offset
- VID_ACK  out  1  one-CE-cycle pulse; VID_D is valid
- VID_D  out  8  video read data
- CPU_REQ  in  1  CPU request, level
- CPU_WE  in  1  1 = write, 0 = read
- CPU_A  in  12  CPU address, same split as VID_A
- CPU_DI  in  8  CPU write data
- CPU_ACK  out  1  one-CE-cycle pulse; access complete, CPU_DO valid on reads
- CPU_DO  out  8  CPU read data
- VA  out  11  VRAM address
- VD_I  in  8  VRAM read data; the RAM is synchronous, so data is valid one CLK after address and nVCS are presented
- VD_O  out  8  VRAM write data
- nVWE  out  1  VRAM write enable, active low
- nVCS  out  2  chip selects, active low; bit 0 = bank A, bit 1 = bank B

## Operation
- States: IDLE, ACC, DATA.
- **IDLE**
  - Arbitrate among pending requests.
  - CPU wins if `CPU_REQ && (!VID_REQ || starve == CPU_STARVE_MAX)`.
  - Otherwise video wins if VID_REQ is high.
  - With no request, remain in IDLE.
- **Grant**
  - Latch owner, WE (forced to 0 for video), address and write data into registers.
  - Go to ACC.
- **ACC**
  - VA = addr[10:0].
  - nVCS[addr[11]] = 0; the other select stays 1.
  - nVWE = ~WE.
  - VD_O = latched data.
  - Go to DATA.
- **DATA**
  - Read: nVCS stays asserted and nVWE = 1.
    - VD_I is registered into VID_D or CPU_DO at the end of DATA.
    - The non-owner's data register holds its value.
  - Write: nVCS = 2'b11 and nVWE = 1 (the write occurred during ACC).
  - The owner's ACK is set at the end of DATA; return to IDLE.
- **ACK**
  - High for exactly the IDLE CE-cycle following DATA; cleared on the next CE edge.
  - A requester may hold REQ high through ACK with a new address/data; it is arbitrated in that same IDLE cycle.
  - REQ, address, WE and DI are sampled only at grant. Later changes have no effect on the access in flight.
- **Starvation counter** (4-bit `starve`)
  - Increments on each video grant made while CPU_REQ = 1, saturating at CPU_STARVE_MAX.
  - Cleared on a CPU grant, or on any IDLE CE edge where CPU_REQ = 0.
- No address bits are remapped. Writes to bank B reach only nVCS[1].

## Timing
- **Reset values** (asynchronous, on nRST = 0)
  - State IDLE; starve = 0.
  - nVCS = 2'b11, nVWE = 1, VA = 0, VD_O = 0.
  - VID_ACK = CPU_ACK = 0; VID_D = CPU_DO = 0.
- **Reset mid-access:** the access is aborted, no ACK is issued, and the chip selects deassert immediately (asynchronously).
- **Latency:** a request seen in IDLE at CE edge k gives ACC after k, DATA after k+1, and ACK plus data valid after k+2.
  - Throughput is one access per 3 CE cycles.
- **CE = 0:** all registers and outputs hold, including an asserted ACK, nVCS and nVWE. The external RAM may therefore rewrite the same data on non-CE clocks; this is harmless.
- Outputs are fully registered; there are no combinational paths from inputs to outputs.
- Only one of nVCS[0] and nVCS[1] is ever low. nVWE = 0 only in ACC of a CPU write.

## Test plan
- **Reset:** hold nRST = 0, toggle CLK, CE = 1 → nVCS = 11, nVWE = 1, both ACKs 0, VA = 0, VD_O = 0. Release → state IDLE, no bus activity.
- **CPU write/read, bank A:** CPU write 0x123 ← 0x5A → in ACC, VA = 0x123, nVCS = 10, nVWE = 0; CPU_ACK 2 CE after grant. Then read 0x123 → CPU_DO = 0x5A with CPU_ACK; nVWE stays 1.
- **Bank B isolation:** CPU write 0x923 ← 0xA5 → nVCS = 01. Read 0x123 → 0x5A (bank A intact); read 0x923 → 0xA5.
- **Contention:** VID_REQ and CPU_REQ held high, CPU_STARVE_MAX = 4 → grant sequence V,V,V,V,C repeating. Every CPU_ACK arrives within 15 CE cycles of the previous one; VID_D is unchanged across CPU accesses.
- **CE gating:** CE toggling 1,0,1,0 during a video read → the same state sequence as the ungated run, stretched 2×. ACK stays high exactly while its IDLE cycle is held.
- **Reset mid-access:** assert nRST during ACC of a CPU write → nVCS = 11 and nVWE = 1 immediately, no CPU_ACK. After release, a pending CPU_REQ is re-granted from IDLE.
